// File: rtl/impostor_disp_pkg.sv
// Shared types and constants for the register display controller.
// Holds the sample FSM encoding and the double-dabble step.
package impostor_disp_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_CAPTURE,
        S_CONVERT,
        S_DONE
    } state_t;

    localparam int BCD_ITER = 14;
    localparam int MAX_DISP = 9999;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_ZERO  = 7'b1000000;

    // {bcd[15:0], bin[13:0]}: add-3 on BCD nibbles >= 5, then shift left
    function automatic logic [29:0] dabble_step(
        input logic [29:0] sr
    );
        logic [29:0] t;
        t = sr;
        for (int i = 0; i < 4; i++) begin
            if (t[14+4*i +: 4] >= 4'd5) begin
                t[14+4*i +: 4] = t[14+4*i +: 4] + 4'd3;
            end
        end
        return {t[28:0], 1'b0};
    endfunction

endpackage

// File: rtl/reg_display_ctrl_if.sv
// Register-file debug read port used by the display controller.
// Data is valid one cycle after the address is stable.
interface reg_display_ctrl_if;

    logic [4:0]  multi_purpose_read_addr;
    logic [31:0] multi_purpose_read_data;

    modport master (
        output multi_purpose_read_addr,
        input  multi_purpose_read_data
    );

    modport slave (
        input  multi_purpose_read_addr,
        output multi_purpose_read_data
    );

endinterface

// File: rtl/seven_seg_decoder.sv
// BCD to active-low seven-segment {g,f,e,d,c,b,a}.
// Non-decimal codes blank the digit.
module seven_seg_decoder
    import impostor_disp_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (bcd)
            4'd0:    seg = 7'b1000000;
            4'd1:    seg = 7'b1111001;
            4'd2:    seg = 7'b0100100;
            4'd3:    seg = 7'b0110000;
            4'd4:    seg = 7'b0011001;
            4'd5:    seg = 7'b0010010;
            4'd6:    seg = 7'b0000010;
            4'd7:    seg = 7'b1111000;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0010000;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/reg_display_ctrl.sv
// Samples a register-file entry, converts it to BCD and
// multiplexes the four digits onto a seven-segment display.
module reg_display_ctrl
    import impostor_disp_pkg::*;
#(
    parameter int SCAN_DIV   = 50000,
    parameter int SAMPLE_DIV = 1000000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [4:0]         reg_sel,
    reg_display_ctrl_if.master rf,
    output logic [3:0]         tho,
    output logic [3:0]         hun,
    output logic [3:0]         ten,
    output logic [3:0]         one,
    output logic [6:0]         seg,
    output logic [3:0]         an,
    output logic               busy,
    output logic               led_indicator
);

    localparam int SMP_W = $clog2(SAMPLE_DIV);
    localparam int SCN_W = $clog2(SCAN_DIV);
    localparam logic [SMP_W-1:0] SMP_LAST =
        SMP_W'(SAMPLE_DIV - 1);
    localparam logic [SCN_W-1:0] SCN_LAST =
        SCN_W'(SCAN_DIV - 1);

    state_t           state_q;
    state_t           state_d;
    logic [4:0]       sel_q;
    logic [SMP_W-1:0] smp_cnt;
    logic             pend_q;
    logic             trig;
    logic [3:0]       iter_q;
    logic [13:0]      bin_q;
    logic [15:0]      bcd_q;
    logic             ovf_q;

    logic [SCN_W-1:0] scn_cnt;
    logic             scn_wrap;
    logic [1:0]       idx_q;
    logic [1:0]       idx_d;
    logic [3:0]       dig_d;
    logic [6:0]       seg_d;

    assign trig = (smp_cnt == SMP_LAST) || (reg_sel != sel_q);
    assign busy = (state_q != S_IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (trig || pend_q) state_d = S_ADDR;
            S_ADDR:    state_d = S_CAPTURE;
            S_CAPTURE: state_d = S_CONVERT;
            S_CONVERT: begin
                if (iter_q == 4'(BCD_ITER - 1)) state_d = S_DONE;
            end
            S_DONE:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // sel_q starts at 31 so the first edge after reset samples
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sel_q   <= 5'h1F;
            smp_cnt <= '0;
            pend_q  <= 1'b0;
        end else begin
            sel_q   <= reg_sel;
            smp_cnt <= (smp_cnt == SMP_LAST) ? '0 : smp_cnt + 1'b1;
            if (state_q == S_IDLE) begin
                pend_q <= 1'b0;
            end else if (trig) begin
                pend_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rf.multi_purpose_read_addr <= '0;
            bin_q         <= '0;
            bcd_q         <= '0;
            ovf_q         <= 1'b0;
            iter_q        <= '0;
            tho           <= '0;
            hun           <= '0;
            ten           <= '0;
            one           <= '0;
            led_indicator <= 1'b0;
        end else begin
            case (state_q)
                S_ADDR: rf.multi_purpose_read_addr <= reg_sel;
                S_CAPTURE: begin
                    if (rf.multi_purpose_read_data > 32'(MAX_DISP)) begin
                        bin_q <= 14'(MAX_DISP);
                        ovf_q <= 1'b1;
                    end else begin
                        bin_q <= rf.multi_purpose_read_data[13:0];
                        ovf_q <= 1'b0;
                    end
                    bcd_q  <= '0;
                    iter_q <= '0;
                end
                S_CONVERT: begin
                    {bcd_q, bin_q} <= dabble_step({bcd_q, bin_q});
                    iter_q <= iter_q + 4'd1;
                end
                S_DONE: begin
                    tho           <= bcd_q[15:12];
                    hun           <= bcd_q[11:8];
                    ten           <= bcd_q[7:4];
                    one           <= bcd_q[3:0];
                    led_indicator <= ovf_q;
                end
                default: ;
            endcase
        end
    end

    assign scn_wrap = (scn_cnt == SCN_LAST);
    assign idx_d    = scn_wrap ? idx_q + 2'd1 : idx_q;

    always_comb begin
        dig_d = one;
        case (idx_d)
            2'd0:    dig_d = one;
            2'd1:    dig_d = ten;
            2'd2:    dig_d = hun;
            default: dig_d = tho;
        endcase
    end

    seven_seg_decoder u_dec (
        .bcd (dig_d),
        .seg (seg_d)
    );

    // an/seg follow the index being loaded so they switch together
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            scn_cnt <= '0;
            idx_q   <= 2'd0;
            an      <= 4'b1110;
            seg     <= SEG_ZERO;
        end else begin
            scn_cnt <= scn_wrap ? '0 : scn_cnt + 1'b1;
            idx_q   <= idx_d;
            an      <= ~(4'b0001 << idx_d);
            seg     <= seg_d;
        end
    end

endmodule

// File: tb/tb_reg_display_ctrl.sv
// Directed bench for reg_display_ctrl with a cycle-level
// reference model and hand-computed spot expectations.
module tb_reg_display_ctrl;

    localparam int CDIV = 4;
    localparam int SDIV = 32;

    logic        clk;
    logic        reset;
    logic [4:0]  reg_sel;
    logic [3:0]  tho, hun, ten, one;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        busy;
    logic        led_indicator;
    logic [31:0] rf [32];

    int total = 0;
    int bad   = 0;

    reg_display_ctrl_if rif ();

    always_comb rif.multi_purpose_read_data = rf[rif.multi_purpose_read_addr];

    reg_display_ctrl #(
        .SCAN_DIV   (CDIV),
        .SAMPLE_DIV (SDIV)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .reg_sel       (reg_sel),
        .rf            (rif),
        .tho           (tho),
        .hun           (hun),
        .ten           (ten),
        .one           (one),
        .seg           (seg),
        .an            (an),
        .busy          (busy),
        .led_indicator (led_indicator)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    logic [6:0] seg_tab [16];
    initial begin
        for (int i = 0; i < 16; i++) seg_tab[i] = 7'h7F;
        seg_tab[0] = 7'b1000000;
        seg_tab[1] = 7'b1111001;
        seg_tab[2] = 7'b0100100;
        seg_tab[3] = 7'b0110000;
        seg_tab[4] = 7'b0011001;
        seg_tab[5] = 7'b0010010;
        seg_tab[6] = 7'b0000010;
        seg_tab[7] = 7'b1111000;
        seg_tab[8] = 7'b0000000;
        seg_tab[9] = 7'b0010000;
    end

    // Reference model: sample runs as a 17-edge timeline after the trigger.
    int          m_k;
    int          m_cnt;
    int          m_phase;
    bit          m_pend;
    logic [4:0]  m_selq;
    logic [4:0]  m_addr;
    logic [31:0] m_val;
    int          m_dig [4];
    bit          m_led;
    logic [3:0]  m_an;
    logic [6:0]  m_seg;

    task automatic m_rst();
        m_k     = 0;
        m_cnt   = 0;
        m_phase = 0;
        m_pend  = 0;
        m_selq  = 5'h1F;
        m_addr  = 5'd0;
        m_val   = 32'd0;
        for (int i = 0; i < 4; i++) m_dig[i] = 0;
        m_led   = 0;
        m_an    = 4'b1110;
        m_seg   = 7'b1000000;
    endtask

    task automatic m_step();
        bit trig;
        int idx;
        int v;
        trig   = (m_cnt == SDIV - 1) || (reg_sel != m_selq);
        m_cnt  = (m_cnt + 1) % SDIV;
        m_selq = reg_sel;
        m_k    = m_k + 1;
        idx    = (m_k / CDIV) % 4;
        m_an   = ~(4'b0001 << idx);
        m_seg  = seg_tab[m_dig[idx]];
        if (m_phase == 0) begin
            if (trig || m_pend) begin
                m_phase = 1;
                m_pend  = 0;
            end
        end else begin
            if (trig) m_pend = 1;
            if (m_phase == 1) begin
                m_addr = reg_sel;
            end else if (m_phase == 2) begin
                m_val = rf[m_addr];
            end else if (m_phase == 17) begin
                v        = (m_val > 32'd9999) ? 9999 : int'(m_val);
                m_led    = (m_val > 32'd9999);
                m_dig[3] = v / 1000;
                m_dig[2] = (v / 100) % 10;
                m_dig[1] = (v / 10) % 10;
                m_dig[0] = v % 10;
            end
            m_phase = (m_phase == 17) ? 0 : m_phase + 1;
        end
    endtask

    initial begin
        m_rst();
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) m_rst();
            else m_step();
        end
    end

    task automatic chk(
        input string       nm,
        input logic [31:0] act,
        input logic [31:0] exp
    );
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)",
                     nm, act, exp, $time);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            chk("busy", 32'(busy), 32'(m_phase != 0));
            chk("addr", 32'(rif.multi_purpose_read_addr), 32'(m_addr));
            chk("digits", {16'd0, tho, hun, ten, one},
                {16'd0, 4'(m_dig[3]), 4'(m_dig[2]),
                 4'(m_dig[1]), 4'(m_dig[0])});
            chk("led", 32'(led_indicator), 32'(m_led));
            chk("an", 32'(an), 32'(m_an));
            chk("seg", 32'(seg), 32'(m_seg));
        end
    end

    task automatic to_edge(input int n);
        int g;
        g = 0;
        while (m_k < n && g < 1000) begin
            @(negedge clk);
            g++;
        end
        chk("sync", 32'(m_k), 32'(n));
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_an"}, 32'(an), 32'h0E);
        chk({tag, "_seg"}, 32'(seg), 32'h40);
        chk({tag, "_dig"}, 32'({tho, hun, ten, one}), 32'h0);
        chk({tag, "_busy"}, 32'(busy), 32'h0);
        chk({tag, "_addr"}, 32'(rif.multi_purpose_read_addr), 32'h0);
        chk({tag, "_led"}, 32'(led_indicator), 32'h0);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = 32'd0;
        rf[3]   = 32'd1234;
        reg_sel = 5'd3;
        reset   = 1'b0;
        #12;
        chk_reset_vals("rst0");
        @(negedge clk);
        reset = 1'b1;

        to_edge(1);
        chk("first_busy", 32'(busy), 32'h1);
        to_edge(18);
        chk("d1234", 32'({tho, hun, ten, one}), 32'h1234);
        chk("d1234_led", 32'(led_indicator), 32'h0);
        chk("d1234_busy", 32'(busy), 32'h0);
        to_edge(19);
        chk("an19", 32'(an), 32'h0E);
        chk("seg_four", 32'(seg), 32'(7'b0011001));
        to_edge(20);
        chk("an20", 32'(an), 32'h0D);
        chk("seg_three", 32'(seg), 32'(7'b0110000));
        rf[3] = 32'hFFFF_FFFF;
        to_edge(24);
        chk("an24", 32'(an), 32'h0B);
        to_edge(28);
        chk("an28", 32'(an), 32'h07);
        to_edge(32);
        chk("an32", 32'(an), 32'h0E);

        to_edge(49);
        chk("clamp", 32'({tho, hun, ten, one}), 32'h9999);
        chk("clamp_led", 32'(led_indicator), 32'h1);
        rf[3] = 32'd0;
        to_edge(81);
        chk("zero", 32'({tho, hun, ten, one}), 32'h0000);
        chk("zero_led", 32'(led_indicator), 32'h0);

        rf[3] = 32'd555;
        rf[7] = 32'd4321;
        to_edge(102);
        chk("conv_busy", 32'(busy), 32'h1);
        reg_sel = 5'd7;
        to_edge(113);
        chk("old_data", 32'({tho, hun, ten, one}), 32'h0555);
        chk("old_addr", 32'(rif.multi_purpose_read_addr), 32'd3);
        to_edge(115);
        chk("new_addr", 32'(rif.multi_purpose_read_addr), 32'd7);
        chk("new_busy", 32'(busy), 32'h1);
        to_edge(131);
        chk("new_data", 32'({tho, hun, ten, one}), 32'h4321);

        rf[3] = 32'd8;
        to_edge(159);
        reg_sel = 5'd3;
        to_edge(177);
        chk("coinc_data", 32'({tho, hun, ten, one}), 32'h0008);
        to_edge(178);
        chk("coinc_once", 32'(busy), 32'h0);
        to_edge(191);
        chk("idle191", 32'(busy), 32'h0);
        to_edge(192);
        chk("tick192", 32'(busy), 32'h1);

        to_edge(200);
        #2;
        reset = 1'b0;
        #1;
        chk_reset_vals("rst_conv");
        @(negedge clk);
        reset = 1'b1;
        to_edge(18);
        chk("after_rst", 32'({tho, hun, ten, one}), 32'h0008);

        @(negedge clk);
        reset   = 1'b0;
        reg_sel = 5'd31;
        rf[31]  = 32'd77;
        @(negedge clk);
        reset = 1'b1;
        to_edge(1);
        chk("sel31_idle", 32'(busy), 32'h0);
        to_edge(32);
        chk("sel31_tick", 32'(busy), 32'h1);
        to_edge(49);
        chk("sel31_data", 32'({tho, hun, ten, one}), 32'h0077);
        to_edge(52);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
